// File: rtl/instr_fetch.sv
// Instruction-fetch unit: holds the PC, fetches words over a valid handshake and computes next PC.
// Optional misaligned-target trap enabled by defining FETCH_ALIGN_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [5:0]  OPcode,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [1:0]  jump,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_error
);

  localparam int unsigned AW = 32;

`ifdef FETCH_ALIGN_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_TRAP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE} state_e;
`endif

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            ivalid_q, ivalid_d;
  logic            req_q, req_d;
  logic [AW-1:0]   pc_plus4_c;
  logic [AW-1:0]   br_off_c;
  logic            taken_c;
  logic [AW-1:0]   next_pc_raw_c;
  logic [AW-1:0]   next_pc_c;
`ifdef FETCH_ALIGN_TRAP_EN
  logic            err_q, err_d;
  logic            misalign_c;
`endif

  // Next-PC computation from the decoder's jump code
  always_comb begin
    pc_plus4_c = pc_q + AW'(4);
    br_off_c   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    taken_c    = branch & (instr_q[26] ? ~zero : zero);
    unique case (jump)
      2'b00:   next_pc_raw_c = pc_plus4_c;
      2'b01:   next_pc_raw_c = {pc_plus4_c[31:28], instr_q[25:0], 2'b00};
      2'b10:   next_pc_raw_c = rs_data;
      default: next_pc_raw_c = taken_c ? (pc_plus4_c + br_off_c) : pc_plus4_c;
    endcase
`ifdef FETCH_ALIGN_TRAP_EN
    misalign_c = (next_pc_raw_c[1:0] != 2'b00);
    next_pc_c  = next_pc_raw_c;
`else
    next_pc_c  = next_pc_raw_c & ~AW'(3);
`endif
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!stall) state_d = S_FETCH;
      S_FETCH: if (imem_valid) state_d = S_ISSUE;
      S_ISSUE: begin
        if (exec_done) begin
`ifdef FETCH_ALIGN_TRAP_EN
          if (misalign_c)  state_d = S_TRAP;
          else if (stall)  state_d = S_IDLE;
          else             state_d = S_FETCH;
`else
          state_d = stall ? S_IDLE : S_FETCH;
`endif
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    ivalid_d = ivalid_q;
    req_d    = (state_d == S_FETCH);
`ifdef FETCH_ALIGN_TRAP_EN
    err_d    = err_q;
`endif
    if (state_q == S_FETCH && imem_valid) begin
      instr_d  = imem_data;
      ivalid_d = 1'b1;
    end
    if (state_q == S_ISSUE && exec_done) begin
      pc_d     = next_pc_c;
      ivalid_d = 1'b0;
`ifdef FETCH_ALIGN_TRAP_EN
      err_d    = misalign_c;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q     <= PC_RESET;
      instr_q  <= 32'h0;
      ivalid_q <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ivalid_q <= ivalid_d;
      req_q    <= req_d;
    end
  end

`ifdef FETCH_ALIGN_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign fetch_error = err_q;
`else
  assign fetch_error = 1'b0;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_c;
  assign instr       = instr_q;
  assign instr_valid = ivalid_q;
  assign OPcode      = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign shamt       = instr_q[10:6];
  assign func        = instr_q[5:0];
  assign imm         = instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch addresses are queued when an instruction
// is retired and compared when the DUT raises the next fetch request.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, imem_valid, exec_done, branch, zero;
  logic [31:0] imem_data, rs_data;
  logic [1:0]  jump;
  logic        imem_req, instr_valid, fetch_error;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  OPcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  // Second instance with a reset PC at the top of the address space
  logic        w_exec_done;
  logic        w_imem_req, w_instr_valid, w_fetch_error;
  logic [31:0] w_imem_addr, w_instr, w_pc, w_pc_plus4;
  logic [5:0]  w_OPcode, w_func;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  instr_fetch #(.PC_RESET(32'h0000_0000)) u_dut (
    .clock(clock), .reset(reset), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .instr(instr), .OPcode(OPcode),
    .func(func), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .instr_valid(instr_valid), .exec_done(exec_done), .jump(jump), .branch(branch),
    .zero(zero), .rs_data(rs_data), .pc(pc), .pc_plus4(pc_plus4), .fetch_error(fetch_error)
  );

  instr_fetch #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
    .clock(clock), .reset(reset), .stall(1'b0), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_valid(1'b1), .imem_data(32'h0), .instr(w_instr), .OPcode(w_OPcode),
    .func(w_func), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt), .imm(w_imm),
    .instr_valid(w_instr_valid), .exec_done(w_exec_done), .jump(2'b00), .branch(1'b0),
    .zero(1'b0), .rs_data(32'h0), .pc(w_pc), .pc_plus4(w_pc_plus4), .fetch_error(w_fetch_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for a request, compare its address against the scoreboard, then answer after 'waits' cycles
  task automatic fetch_word(input logic [31:0] data, input int waits);
    int t = 0;
    logic [31:0] ea = 32'h0;
    while (!imem_req && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!imem_req) begin
      check_eq("req_timeout", 32'(imem_req), 32'h1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", imem_addr, 32'hFFFF_FFFF);
    end else begin
      ea = exp_q.pop_front();
      check_eq("imem_addr", imem_addr, ea);
    end
    if (waits > 0) begin
      repeat (waits) @(negedge clock);
      check_eq("addr_hold", imem_addr, ea);
      check_eq("req_hold", 32'(imem_req), 32'h1);
    end
    imem_valid = 1'b1;
    imem_data  = data;
    @(negedge clock);
    imem_valid = 1'b0;
    imem_data  = 32'hDEAD_BEEF;
    check_eq("instr_valid", 32'(instr_valid), 32'h1);
    check_eq("instr", instr, data);
  endtask

  task automatic exec(input logic [1:0] j, input logic b, input logic z,
                      input logic [31:0] rsd, input logic st);
    exec_done = 1'b1;
    jump      = j;
    branch    = b;
    zero      = z;
    rs_data   = rsd;
    stall     = st;
    @(negedge clock);
    exec_done = 1'b0;
    jump      = 2'b00;
    branch    = 1'b0;
    zero      = 1'b0;
    check_eq("ivalid_clear", 32'(instr_valid), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; imem_valid = 1'b0; imem_data = 32'h0;
    exec_done = 1'b0; jump = 2'b00; branch = 1'b0; zero = 1'b0; rs_data = 32'h0;
    w_exec_done = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_req", 32'(imem_req), 32'h0);
    check_eq("rst_ivalid", 32'(instr_valid), 32'h0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_err", 32'(fetch_error), 32'h0);
    check_eq("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Wrap-around: top-of-memory PC plus four lands on zero
    @(negedge clock);
    check_eq("wrap_req", 32'(w_imem_req), 32'h1);
    check_eq("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
    @(negedge clock);
    check_eq("wrap_pc_plus4", w_pc_plus4, 32'h0);
    w_exec_done = 1'b1;
    @(negedge clock);
    w_exec_done = 1'b0;
    check_eq("wrap_addr1", w_imem_addr, 32'h0);
    check_eq("wrap_req1", 32'(w_imem_req), 32'h1);

    // Basic fetch with two wait cycles
    exp_q.push_back(32'h0);
    fetch_word(32'h2008_0005, 2);
    check_eq("opcode", 32'(OPcode), 32'h08);
    check_eq("rt", 32'(rt), 32'd8);
    check_eq("imm", 32'(imm), 32'h5);
    check_eq("rs", 32'(rs), 32'd0);
    exp_q.push_back(32'h4);
    exec(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch_word(32'h0, 0);

    // beq taken / not taken, bne taken, branch=0 not taken
    exp_q.push_back(32'h10); exec(2'b10, 1'b0, 1'b0, 32'h10, 1'b0);
    fetch_word(32'h1109_FFFC, 0);
    exp_q.push_back(32'h4);  exec(2'b11, 1'b1, 1'b1, 32'h0, 1'b0);
    fetch_word(32'h0, 0);
    exp_q.push_back(32'h10); exec(2'b10, 1'b0, 1'b0, 32'h10, 1'b0);
    fetch_word(32'h1109_FFFC, 0);
    exp_q.push_back(32'h14); exec(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
    fetch_word(32'h0, 1);
    exp_q.push_back(32'h10); exec(2'b10, 1'b0, 1'b0, 32'h10, 1'b0);
    fetch_word(32'h1509_FFFC, 0);
    exp_q.push_back(32'h4);  exec(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
    fetch_word(32'h1109_FFFC, 0);
    exp_q.push_back(32'h8);  exec(2'b11, 1'b0, 1'b1, 32'h0, 1'b0);
    fetch_word(32'h0, 0);

    // j and jal from 0x40
    exp_q.push_back(32'h40); exec(2'b10, 1'b0, 1'b0, 32'h40, 1'b0);
    fetch_word(32'h0800_0100, 0);
    exp_q.push_back(32'h400); exec(2'b01, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch_word(32'h012A_4020, 0);
    check_eq("r_rs", 32'(rs), 32'd9);
    check_eq("r_rt", 32'(rt), 32'd10);
    check_eq("r_rd", 32'(rd), 32'd8);
    check_eq("r_shamt", 32'(shamt), 32'd0);
    check_eq("r_func", 32'(func), 32'h20);
    exp_q.push_back(32'h40); exec(2'b10, 1'b0, 1'b0, 32'h40, 1'b0);
    fetch_word(32'h0C00_0100, 0);
    check_eq("jal_pc", pc, 32'h40);
    check_eq("jal_link", pc_plus4, 32'h44);
    exp_q.push_back(32'h400); exec(2'b01, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch_word(32'h0, 0);

    // jr, then a stray exec_done while fetching
    exp_q.push_back(32'h1230); exec(2'b10, 1'b0, 1'b0, 32'h1230, 1'b0);
    exec_done = 1'b1; jump = 2'b10; rs_data = 32'h5550;
    @(negedge clock);
    exec_done = 1'b0; jump = 2'b00;
    check_eq("stray_pc", pc, 32'h1230);
    check_eq("stray_addr", imem_addr, 32'h1230);
    fetch_word(32'h0, 3);

    // Stall at retirement parks in IDLE; release resumes fetching next cycle
    exec(2'b00, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("stall_req0", 32'(imem_req), 32'h0);
    @(negedge clock);
    check_eq("stall_req1", 32'(imem_req), 32'h0);
    stall = 1'b0;
    @(negedge clock);
    check_eq("unstall_req", 32'(imem_req), 32'h1);
    exp_q.push_back(32'h1234);
    fetch_word(32'h0, 0);

    // Asynchronous reset while a request is outstanding
    exec(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("pre_rst_req", 32'(imem_req), 32'h1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_req", 32'(imem_req), 32'h0);
    check_eq("async_rst_pc", pc, 32'h0);
    check_eq("async_rst_ivalid", 32'(instr_valid), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.push_back(32'h0);
    fetch_word(32'h0320_0008, 0);

    // Misaligned jr target
`ifdef FETCH_ALIGN_TRAP_EN
    exec(2'b10, 1'b0, 1'b0, 32'h1232, 1'b0);
    check_eq("trap_err", 32'(fetch_error), 32'h1);
    check_eq("trap_pc", pc, 32'h1232);
    begin
      logic seen_req = 1'b0;
      repeat (5) begin
        @(negedge clock);
        seen_req = seen_req | imem_req;
      end
      check_eq("trap_no_req", 32'(seen_req), 32'h0);
    end
`else
    exp_q.push_back(32'h1230);
    exec(2'b10, 1'b0, 1'b0, 32'h1232, 1'b0);
    check_eq("no_trap_err", 32'(fetch_error), 32'h0);
    fetch_word(32'h0, 0);
`endif

    check_eq("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
